// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU/CALL and load writebacks onto a single
// register-file write port. ALU requests are buffered in a 2-entry FIFO;
// loads win by default, with a starvation counter forcing the FIFO head
// after STARVE_MAX consecutive load grants, and a same-register check that
// holds loads off until older ALU writes to that register have drained.
// Optional feature: define WB_BYPASS_EN to let an ALU request skip the
// empty FIFO and reach the output register with 1-cycle latency.
module wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  output logic        rf_we,
  output logic [3:0]  rf_addr,
  output logic [15:0] rf_data,
  output logic        busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // Registered state mirrors what was written last cycle; IDLE means no write.
  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, FORCE} state_t;
  state_t state;

  logic [1:0][3:0]  fifo_addr;
  logic [1:0][15:0] fifo_data;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;
  logic [SW-1:0]    starve;

  logic empty, full, hazard, force_grant;
  logic ld_grant, deq, alu_acc, enq, bypass_go;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign busy  = !empty;

  // A load may not overtake a buffered ALU write to the same register.
  assign hazard = (!empty && fifo_addr[rd_ptr]  == ld_addr) ||
                  (full   && fifo_addr[~rd_ptr] == ld_addr);

  assign force_grant = (starve == STARVE_LIM) && !empty;

  // Ready outputs are gated by reset so nothing is accepted while held low.
  assign ld_ready  = rst_n && !force_grant && !hazard;
  assign ld_grant  = ld_valid && ld_ready;
  assign deq       = !ld_grant && !empty;
  assign alu_ready = rst_n && (!full || deq);
  assign alu_acc   = alu_valid && alu_ready;

`ifdef WB_BYPASS_EN
  assign bypass_go = alu_acc && empty && !ld_grant;
`else
  assign bypass_go = 1'b0;
`endif

  assign enq   = alu_acc && !bypass_go;
  assign rf_we = (state != IDLE);

  // Grant FSM: picks the single writer for this cycle and registers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rf_addr <= 4'h0;
      rf_data <= 16'h0000;
    end else if (ld_grant) begin
      state   <= LOAD;
      rf_addr <= ld_addr;
      rf_data <= ld_data;
    end else if (deq) begin
      state   <= force_grant ? FORCE : DRAIN;
      rf_addr <= fifo_addr[rd_ptr];
      rf_data <= fifo_data[rd_ptr];
    end else if (bypass_go) begin
      state   <= DRAIN;
      rf_addr <= alu_addr;
      rf_data <= alu_data;
    end else begin
      state   <= IDLE;
    end
  end

  // ALU FIFO storage, 1-bit wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_addr <= '0;
      fifo_data <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (enq) begin
        fifo_addr[wr_ptr] <= alu_addr;
        fifo_data[wr_ptr] <= alu_data;
        wr_ptr            <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts load grants that bypassed a waiting ALU entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             starve <= '0;
    else if (deq || empty)                  starve <= '0;
    else if (ld_grant && starve != STARVE_LIM) starve <= starve + 1'b1;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive load-granted cycles after which a waiting ALU entry wins the port.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 alu_valid  input  1  SHALL indicate an ALU/CALL writeback request.
REQ-005 alu_addr  input  4  SHALL be the destination register; 4'hF for CALL/RET link writes.
REQ-006 alu_data  input  16  SHALL be the ALU writeback value.
REQ-007 alu_ready  output  1  SHALL be high when the ALU request is accepted this cycle.
REQ-008 ld_valid  input  1  SHALL indicate a load-data writeback request.
REQ-009 ld_addr  input  4  SHALL be the load destination register.
REQ-010 ld_data  input  16  SHALL be the load data.
REQ-011 ld_ready  output  1  SHALL be high when the load request is accepted this cycle.
REQ-012 rf_we  output  1  SHALL be the registered register-file write enable.
REQ-013 rf_addr  output  4  SHALL be the registered write address.
REQ-014 rf_data  output  16  SHALL be the registered write data.
REQ-015 busy  output  1  SHALL be high while the ALU FIFO holds any entry.

Function
REQ-016 Block SHALL issue at most one register-file write per cycle; rf_we/rf_addr/rf_data registered, valid the cycle after grant.
REQ-017 ALU requests SHALL enqueue into a 2-entry FIFO (addr+data); alu_ready = FIFO not full, or FIFO full with a dequeue this cycle.
REQ-018 Grant each cycle: load if ld_valid and ld_ready; else FIFO head if non-empty; else no write (rf_we=0).
REQ-019 Starvation counter SHALL increment (saturating at STARVE_MAX) each cycle a load is granted while FIFO non-empty; clear on any FIFO dequeue or FIFO empty.
REQ-020 When counter == STARVE_MAX, FIFO head SHALL be granted and ld_ready SHALL be 0 that cycle.
REQ-021 Ordering: ld_ready SHALL be 0 while any FIFO entry has addr == ld_addr; FIFO drains first.
REQ-022 Simultaneous enqueue and dequeue on a full FIFO SHALL leave count 2 with correct order; on empty FIFO (without bypass) SHALL leave count 1.
REQ-023 FIFO pointers SHALL be 1-bit and wrap 1->0; count range 0..2, never exceeds 2.
REQ-024 No request SHALL be dropped or duplicated; each accepted request produces exactly one rf_we pulse.
REQ-025 States: IDLE (no pending), DRAIN (FIFO non-empty, no load), LOAD (load granted), FORCE (starvation grant); transitions per REQ-018..021 each cycle.

Reset
REQ-026 On rst_n low, asynchronously: rf_we=0, rf_addr=4'h0, rf_data=16'h0000, FIFO count=0, pointers=0, starvation counter=0, state IDLE.
REQ-027 Reset mid-operation SHALL discard all FIFO contents; alu_ready=1 and ld_ready=1 from the first cycle after rst_n rises.
REQ-028 Requests present while rst_n is low SHALL NOT be accepted.

Configuration
REQ-029 Macro WB_BYPASS_EN defined: when FIFO empty and load not granted, an accepted ALU request SHALL go directly to the output register (1-cycle latency, FIFO unchanged).
REQ-030 WB_BYPASS_EN undefined: every ALU request SHALL pass through the FIFO (minimum 2-cycle latency to rf_we).

Verification
REQ-031 Single ALU write r3=16'h1234, idle otherwise -> rf_we with addr 3, data 16'h1234 one cycle later (bypass) / two cycles later (no bypass).
REQ-032 ALU (r2=16'hAAAA) and load (r5=16'h5555) same cycle, FIFO empty -> r5 written first, r2 next cycle.
REQ-033 Continuous ld_valid plus one queued ALU entry -> ALU entry written after exactly STARVE_MAX=4 load writes; ld_ready low that cycle.
REQ-034 FIFO holds r7; load to r7 arrives -> ld_ready=0 until r7 ALU write issued, then load written.
REQ-035 Three back-to-back ALU writes under continuous loads -> alu_ready drops on third, all three written in order.
REQ-036 rst_n asserted with FIFO count 2 -> rf_we=0 immediately, busy=0, no stale writes after release.
